pc_fetch_ctrl: RTL and testbench

//   Owns the program counter and drives instruction fetch for the MIPS core.

---
 rtl/pc_fetch_ctrl_pkg.sv | 10 +
 rtl/pc_fetch_ctrl_if.sv | 9 +
 rtl/pc_fetch_ctrl_pc_next_sel.sv | 25 ++
 rtl/pc_fetch_ctrl.sv | 68 ++++++
 tb/tb_pc_fetch_ctrl.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_ctrl_pkg: shared fetch FSM encoding and PC width/reset defaults
package pc_fetch_ctrl_pkg;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if: instruction memory req/ack fetch port
interface pc_fetch_ctrl_if;
  import pc_fetch_ctrl_pkg::*;
  logic            req;
  logic [PC_W-1:0] addr;
  logic            ack;
  modport master (output req, output addr, input ack);
  modport slave  (input req, input addr, output ack);
endinterface

// File: rtl/pc_fetch_ctrl_pc_next_sel.sv
// pc_next_sel: pc+4 adder, jr > jump > branch > sequential next-PC mux, jr misalign detect
module pc_next_sel
  import pc_fetch_ctrl_pkg::*;
(
  input  logic [PC_W-1:0] pc_i,
  input  logic            branch_taken_i,
  input  logic [PC_W-1:0] branch_off_i,
  input  logic            jump_i,
  input  logic [25:0]     jump_idx_i,
  input  logic            jr_i,
  input  logic [PC_W-1:0] jr_addr_i,
  output logic [PC_W-1:0] pc_plus4_o,
  output logic [PC_W-1:0] next_pc_o,
  output logic            misalign_o
);
  logic [PC_W-1:0] br_tgt, j_tgt, jr_tgt;
  logic            unused_off;
  assign unused_off = ^branch_off_i[31:30];
  assign pc_plus4_o = pc_i + 32'd4;
  assign br_tgt     = pc_plus4_o + {branch_off_i[29:0], 2'b00};
  assign j_tgt      = {pc_plus4_o[31:28], jump_idx_i, 2'b00};
  assign jr_tgt     = {jr_addr_i[31:2], 2'b00};
  assign next_pc_o  = jr_i ? jr_tgt : jump_i ? j_tgt : branch_taken_i ? br_tgt : pc_plus4_o;
  assign misalign_o = jr_i && (jr_addr_i[1:0] != 2'b00);
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC register and BOOT/FETCH/ISSUE instruction fetch handshake
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic                 branch_taken_i,
  input  logic [PC_W-1:0]      branch_off_i,
  input  logic                 jump_i,
  input  logic [25:0]          jump_idx_i,
  input  logic                 jr_i,
  input  logic [PC_W-1:0]      jr_addr_i,
  pc_fetch_ctrl_if.master      imem,
  output logic [PC_W-1:0]      pc_o,
  output logic [PC_W-1:0]      pc_plus4_o,
  output logic                 inst_valid_o,
  output logic                 pc_misalign_o
);
  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, next_pc;
  logic            misalign, advance;

  pc_next_sel u_next (
    .pc_i           (pc_q),
    .branch_taken_i (branch_taken_i),
    .branch_off_i   (branch_off_i),
    .jump_i         (jump_i),
    .jump_idx_i     (jump_idx_i),
    .jr_i           (jr_i),
    .jr_addr_i      (jr_addr_i),
    .pc_plus4_o     (pc_plus4_o),
    .next_pc_o      (next_pc),
    .misalign_o     (misalign)
  );

  assign advance = (state_q == ISSUE) && !stall_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Redirects are only sampled on the ISSUE->FETCH transition; ack only counts in FETCH.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    state_d       = (state_q == FETCH) ? (imem.ack ? ISSUE : FETCH) :
                    (state_q == ISSUE) ? (stall_i ? ISSUE : FETCH) : FETCH;
    pc_d          = advance ? next_pc : pc_q;
    imem.req      = (state_q == FETCH);
    imem.addr     = pc_q;
    inst_valid_o  = (state_q == ISSUE);
    pc_misalign_o = advance && misalign;
    pc_o          = pc_q;
  end

  a_req_hold: assert property (@(posedge clk) disable iff (rst)
    (state_q == FETCH && !imem.ack) |=> (state_q == FETCH && $stable(pc_q)));
  a_pc_align: assert property (@(posedge clk) disable iff (rst) pc_q[1:0] == 2'b00);
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed checks of reset, fetch handshake, redirects, stall and wrap
module tb_pc_fetch_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        stall = 0, branch_taken = 0, jump = 0, jr = 0;
  logic [31:0] branch_off = 0, jr_addr = 0;
  logic [25:0] jump_idx = 0;
  logic [31:0] pc, pc_plus4;
  logic        inst_valid, pc_misalign;
  int          n_cmp = 0, n_fail = 0;

  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl dut (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_taken_i(branch_taken),
    .branch_off_i(branch_off), .jump_i(jump), .jump_idx_i(jump_idx), .jr_i(jr),
    .jr_addr_i(jr_addr), .imem(bus.master), .pc_o(pc), .pc_plus4_o(pc_plus4),
    .inst_valid_o(inst_valid), .pc_misalign_o(pc_misalign)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Wait (bounded) for a request, ack it in one cycle, leave the DUT in ISSUE.
  task automatic do_fetch();
    int t = 0;
    while (bus.req !== 1'b1 && t < 10) begin step(); t++; end
    n_cmp++; if (bus.req !== 1'b1) begin n_fail++; $display("FAIL fetch_timeout req=%b want 1", bus.req); end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
  endtask

  task automatic test_reset();
    bus.ack = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b want 0", bus.req); end
    n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h want 0", pc); end
    rst = 1'b0;
    n_cmp++; if (bus.req !== 1'b0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL boot_outs req=%b iv=%b want 0 0", bus.req, inst_valid); end
    step();
    n_cmp++; if (bus.req !== 1'b1 || bus.addr !== 32'h0) begin n_fail++; $display("FAIL first_fetch req=%b addr=%h want 1 0", bus.req, bus.addr); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL async_drop req=%b want 0", bus.req); end
    @(negedge clk);
    rst = 1'b0;
    bus.ack = 1'b1;
    step();
    n_cmp++; if (bus.req !== 1'b1 || inst_valid !== 1'b0 || bus.addr !== 32'h0) begin n_fail++; $display("FAIL boot_ack_ignored req=%b iv=%b addr=%h want 1 0 0", bus.req, inst_valid, bus.addr); end
    bus.ack = 1'b0;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.addr !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_addr%0d got %h want %h", i, bus.addr, i * 4); end
      do_fetch();
      n_cmp++; if (inst_valid !== 1'b1 || pc !== 32'(i * 4) || pc_plus4 !== 32'(i * 4 + 4) || bus.req !== 1'b0)
        begin n_fail++; $display("FAIL seq_issue%0d iv=%b pc=%h p4=%h req=%b want 1 %h %h 0", i, inst_valid, pc, pc_plus4, bus.req, i * 4, i * 4 + 4); end
      step();
    end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus.req !== 1'b1 || bus.addr !== 32'h10 || inst_valid !== 1'b0)
        begin n_fail++; $display("FAIL wait%0d req=%b addr=%h iv=%b want 1 10 0", i, bus.req, bus.addr, inst_valid); end
      step();
    end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    n_cmp++; if (inst_valid !== 1'b1 || pc !== 32'h10) begin n_fail++; $display("FAIL wait_issue iv=%b pc=%h want 1 10", inst_valid, pc); end
    jr = 1'b1; jr_addr = 32'h100;
    n_cmp++; if (pc_misalign !== 1'b0) begin n_fail++; $display("FAIL aligned_jr misalign=%b want 0", pc_misalign); end
    step();
    jr = 1'b0;
    n_cmp++; if (bus.addr !== 32'h100 || bus.req !== 1'b1) begin n_fail++; $display("FAIL jr_target addr=%h req=%b want 100 1", bus.addr, bus.req); end
  endtask

  task automatic test_branch();
    do_fetch();
    branch_taken = 1'b1; branch_off = 32'hFFFF_FFFE;
    step();
    branch_taken = 1'b0;
    n_cmp++; if (pc !== 32'h0000_00FC) begin n_fail++; $display("FAIL branch_back pc=%h want 000000fc", pc); end
    do_fetch();
    jr = 1'b1; jr_addr = 32'h1000_0000;
    step();
    jr = 1'b0;
    do_fetch();
    jump = 1'b1; jump_idx = 26'h0000040;
    step();
    jump = 1'b0;
    n_cmp++; if (pc !== 32'h1000_0100) begin n_fail++; $display("FAIL jump pc=%h want 10000100", pc); end
  endtask

  task automatic test_priority();
    do_fetch();
    jr = 1'b1; jump = 1'b1; branch_taken = 1'b1;
    jr_addr = 32'h203; jump_idx = 26'h0000777; branch_off = 32'h4;
    #1;
    n_cmp++; if (pc_misalign !== 1'b1) begin n_fail++; $display("FAIL misalign_pulse got %b want 1", pc_misalign); end
    step();
    jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    n_cmp++; if (pc !== 32'h200) begin n_fail++; $display("FAIL priority pc=%h want 00000200", pc); end
    n_cmp++; if (pc_misalign !== 1'b0) begin n_fail++; $display("FAIL misalign_one_cycle got %b want 0", pc_misalign); end
  endtask

  task automatic test_stall_wrap();
    do_fetch();
    stall = 1'b1; jump = 1'b1; jump_idx = 26'h0000123; bus.ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (pc !== 32'h200 || inst_valid !== 1'b1 || bus.req !== 1'b0)
        begin n_fail++; $display("FAIL stall%0d pc=%h iv=%b req=%b want 200 1 0", i, pc, inst_valid, bus.req); end
    end
    stall = 1'b0; jump = 1'b0; bus.ack = 1'b0;
    jr = 1'b1; jr_addr = 32'hFFFF_FFFC;
    step();
    jr = 1'b0;
    do_fetch();
    n_cmp++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_p4 pc=%h p4=%h want fffffffc 0", pc, pc_plus4); end
    step();
    n_cmp++; if (pc !== 32'h0 || bus.addr !== 32'h0 || bus.req !== 1'b1) begin n_fail++; $display("FAIL wrap_pc pc=%h addr=%h req=%b want 0 0 1", pc, bus.addr, bus.req); end
  endtask

  initial begin
    bus.ack = 1'b0;
    test_reset();
    test_sequential();
    test_wait_states();
    test_branch();
    test_priority();
    test_stall_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
